// File: rtl/usb_txn_ctrl_pkg.sv
// rtl/usb_txn_ctrl_pkg.sv - shared PIDs, address, transaction codes and enums for usb_txn_ctrl
package usb_txn_ctrl_pkg;

  localparam logic [7:0] PID_OUT   = 8'b10000111;
  localparam logic [7:0] PID_IN    = 8'b10010110;
  localparam logic [7:0] PID_DATA0 = 8'b11000011;
  localparam logic [7:0] PID_ACK   = 8'b01001011;
  localparam logic [7:0] PID_NAK   = 8'b01011010;

  localparam logic [6:0] ADDR = 7'b1010000;

  localparam logic [1:0] TRANS_IN  = 2'b01;
  localparam logic [1:0] TRANS_OUT = 2'b10;

  localparam int unsigned TIMEOUT_LEN = 255;

  typedef enum logic [1:0] {
    KIND_TOKEN = 2'b00,
    KIND_DATA  = 2'b01,
    KIND_HS    = 2'b10
  } tx_kind_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TOK,
    ST_TOK_W,
    ST_DATA,
    ST_DATA_W,
    ST_RESP,
    ST_HS,
    ST_HS_W,
    ST_FIN
  } state_t;

  // Only IN and OUT requests start a transaction; the other codes are dropped.
  function automatic logic valid_type(input logic [1:0] t);
    return (t == TRANS_IN) || (t == TRANS_OUT);
  endfunction

endpackage

// File: rtl/usb_txn_ctrl_if.sv
// rtl/usb_txn_ctrl_if.sv - task-layer, encoder and decoder signals of usb_txn_ctrl
interface usb_txn_ctrl_if;

  logic        txn_start;
  logic [1:0]  txn_type;
  logic [3:0]  txn_endp;
  logic [63:0] txn_wdata;
  logic        txn_done;
  logic        txn_ok;
  logic [63:0] txn_rdata;

  logic        tx_load;
  logic [1:0]  tx_kind;
  logic [7:0]  tx_pid;
  logic [6:0]  tx_addr;
  logic [3:0]  tx_endp;
  logic [63:0] tx_data;
  logic        tx_done;

  logic        rx_en;
  logic        rx_valid;
  logic [7:0]  rx_pid;
  logic [63:0] rx_data;
  logic        rx_err;

  // Sequencer side.
  modport master (
    input  txn_start, txn_type, txn_endp, txn_wdata,
    input  tx_done, rx_valid, rx_pid, rx_data, rx_err,
    output txn_done, txn_ok, txn_rdata,
    output tx_load, tx_kind, tx_pid, tx_addr, tx_endp, tx_data, rx_en
  );

  // Task layer, encoder and decoder side.
  modport slave (
    output txn_start, txn_type, txn_endp, txn_wdata,
    output tx_done, rx_valid, rx_pid, rx_data, rx_err,
    input  txn_done, txn_ok, txn_rdata,
    input  tx_load, tx_kind, tx_pid, tx_addr, tx_endp, tx_data, rx_en
  );

endinterface

// File: rtl/usb_resp_timer.sv
// rtl/usb_resp_timer.sv - 8-bit response wait counter with clear, enable and expiry flag
module usb_resp_timer
  import usb_txn_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_LEN
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  // Count the wait cycles already spent; clear restarts from zero.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)      count <= '0;
    else if (clr)    count <= '0;
    else if (en)     count <= count + 8'd1;
  end

  // Expiry marks the wait cycle whose increment brings the count to LIMIT,
  // so the wait lasts exactly LIMIT cycles.
  assign expired = en && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/usb_txn_ctrl.sv
// rtl/usb_txn_ctrl.sv - host USB IN/OUT transaction sequencer; retry path enabled by USB_TXN_RETRY_EN
module usb_txn_ctrl
  import usb_txn_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_LEN
`ifdef USB_TXN_RETRY_EN
  , parameter int unsigned MAX_RETRY = 8
`endif
) (
  input logic           clk,
  input logic           rst_b,
  usb_txn_ctrl_if.master bus
);

  state_t      state, state_n;
  logic        is_in;
  logic [3:0]  endp_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        good_q, good_n;
  logic        ok_q;
  tx_kind_t    kind_q, kind_n;
  logic [7:0]  pid_q, pid_n;

  logic accept, pkt_upd, cap_rdata, fin_upd, fin_ok, take_fail;
  logic tmr_expired;

`ifdef USB_TXN_RETRY_EN
  logic [3:0] retry_q;
  logic       retry_inc;
`endif

  usb_resp_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr     (state != ST_RESP),
    .en      (state == ST_RESP),
    .expired (tmr_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next state plus the packet/result updates that go with each transition.
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    pkt_upd   = 1'b0;
    kind_n    = kind_q;
    pid_n     = pid_q;
    cap_rdata = 1'b0;
    good_n    = good_q;
    fin_upd   = 1'b0;
    fin_ok    = 1'b0;
    take_fail = 1'b0;
`ifdef USB_TXN_RETRY_EN
    retry_inc = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (bus.txn_start && valid_type(bus.txn_type)) begin
          accept  = 1'b1;
          state_n = ST_TOK;
          pkt_upd = 1'b1;
          kind_n  = KIND_TOKEN;
          pid_n   = (bus.txn_type == TRANS_IN) ? PID_IN : PID_OUT;
        end
      end
      ST_TOK:   state_n = ST_TOK_W;
      ST_TOK_W: begin
        if (bus.tx_done) begin
          if (is_in) begin
            state_n = ST_RESP;
          end else begin
            state_n = ST_DATA;
            pkt_upd = 1'b1;
            kind_n  = KIND_DATA;
            pid_n   = PID_DATA0;
          end
        end
      end
      ST_DATA:   state_n = ST_DATA_W;
      ST_DATA_W: if (bus.tx_done) state_n = ST_RESP;
      ST_RESP: begin
        // A response arriving on the expiry cycle still counts.
        if (bus.rx_valid) begin
          if (is_in) begin
            state_n = ST_HS;
            pkt_upd = 1'b1;
            kind_n  = KIND_HS;
            if (bus.rx_pid == PID_DATA0 && !bus.rx_err) begin
              cap_rdata = 1'b1;
              good_n    = 1'b1;
              pid_n     = PID_ACK;
            end else begin
              good_n = 1'b0;
              pid_n  = PID_NAK;
            end
          end else if (bus.rx_pid == PID_ACK && !bus.rx_err) begin
            state_n = ST_FIN;
            fin_upd = 1'b1;
            fin_ok  = 1'b1;
          end else begin
            take_fail = 1'b1;
          end
        end else if (tmr_expired) begin
          take_fail = 1'b1;
        end
      end
      ST_HS:   state_n = ST_HS_W;
      ST_HS_W: begin
        if (bus.tx_done) begin
          if (good_q) begin
            state_n = ST_FIN;
            fin_upd = 1'b1;
            fin_ok  = 1'b1;
          end else begin
            take_fail = 1'b1;
          end
        end
      end
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // Failure path: restart from the token while retries remain, else finish with ok = 0.
    if (take_fail) begin
`ifdef USB_TXN_RETRY_EN
      if (retry_q < 4'(MAX_RETRY)) begin
        retry_inc = 1'b1;
        state_n   = ST_TOK;
        pkt_upd   = 1'b1;
        kind_n    = KIND_TOKEN;
        pid_n     = is_in ? PID_IN : PID_OUT;
      end else begin
        state_n = ST_FIN;
        fin_upd = 1'b1;
        fin_ok  = 1'b0;
      end
`else
      state_n = ST_FIN;
      fin_upd = 1'b1;
      fin_ok  = 1'b0;
`endif
    end
  end

  // Transaction context, outgoing packet fields and result registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      is_in   <= 1'b0;
      endp_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      good_q  <= 1'b0;
      ok_q    <= 1'b0;
      kind_q  <= KIND_TOKEN;
      pid_q   <= '0;
    end else begin
      if (accept) begin
        is_in   <= (bus.txn_type == TRANS_IN);
        endp_q  <= bus.txn_endp;
        wdata_q <= bus.txn_wdata;
        ok_q    <= 1'b0;
      end else if (fin_upd) begin
        ok_q <= fin_ok;
      end
      if (pkt_upd) begin
        kind_q <= kind_n;
        pid_q  <= pid_n;
      end
      if (cap_rdata) rdata_q <= bus.rx_data;
      good_q <= good_n;
    end
  end

`ifdef USB_TXN_RETRY_EN
  // Retry count: cleared per transaction, bumped on each retried failure; stops at MAX_RETRY.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)         retry_q <= '0;
    else if (accept)    retry_q <= '0;
    else if (retry_inc) retry_q <= retry_q + 4'd1;
  end
`endif

  assign bus.tx_load   = (state == ST_TOK) || (state == ST_DATA) || (state == ST_HS);
  assign bus.tx_kind   = kind_q;
  assign bus.tx_pid    = pid_q;
  assign bus.tx_addr   = ADDR;
  assign bus.tx_endp   = endp_q;
  assign bus.tx_data   = wdata_q;
  assign bus.rx_en     = (state == ST_RESP);
  assign bus.txn_done  = (state == ST_FIN);
  assign bus.txn_ok    = ok_q;
  assign bus.txn_rdata = rdata_q;

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// tb/tb_usb_txn_ctrl.sv - self-checking bench for usb_txn_ctrl with encoder/device model
module tb_usb_txn_ctrl;

  localparam int ENC_LAT = 3;
  localparam int T_LIMIT = 255;
`ifdef USB_TXN_RETRY_EN
  localparam int RETRIES = 8;
`else
  localparam int RETRIES = 0;
`endif

  typedef enum int {R_NONE, R_ACK, R_NAK, R_DATA, R_ERR} resp_t;
  typedef struct { logic [1:0] kind; logic [7:0] pid; } pkt_t;
  typedef struct { logic ok; bit chk_rd; logic [63:0] rd; } res_t;

  logic clk = 1'b0;
  logic rst_b;
  usb_txn_ctrl_if bus ();

  usb_txn_ctrl dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  pkt_t exp_pkt[$];
  int   exp_win[$];
  res_t exp_res[$];

  resp_t       scr_kind[16];
  int          scr_delay[16];
  logic [63:0] scr_data;

  logic [1:0]  cur_type;
  logic [3:0]  cur_endp;
  logic [63:0] cur_wdata;
  pkt_t        cur_pkt;
  bit          in_flight;
  int          enc_cnt;
  int          win;
  bit          rx_prev;
  int          att;
  int          n_loads;
  int          n_dones;
  logic        last_ok;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input logic [1:0] k, input logic [7:0] p);
    pkt_t x;
    x.kind = k;
    x.pid  = p;
    exp_pkt.push_back(x);
  endtask

  task automatic clear_script();
    for (int i = 0; i < 16; i++) begin
      scr_kind[i]  = R_NONE;
      scr_delay[i] = 0;
    end
    scr_data = '0;
  endtask

  // Model: walk the device script attempt by attempt and list every packet,
  // response window length and the final result the transaction must produce.
  task automatic prepare(input logic [1:0] t, input logic [3:0] e, input logic [63:0] w);
    bit   fin;
    bit   in_t;
    res_t r;
    cur_type  = t;
    cur_endp  = e;
    cur_wdata = w;
    in_t = (t == 2'b01);
    fin  = 1'b0;
    for (int a = 0; a <= RETRIES && !fin; a++) begin
      push_pkt(2'b00, in_t ? 8'h96 : 8'h87);
      if (!in_t) push_pkt(2'b01, 8'hC3);
      exp_win.push_back(scr_kind[a] == R_NONE ? T_LIMIT : scr_delay[a]);
      if (in_t) begin
        if (scr_kind[a] == R_DATA) begin
          push_pkt(2'b10, 8'h4B);
          r.ok = 1'b1; r.chk_rd = 1'b1; r.rd = scr_data;
          exp_res.push_back(r);
          fin = 1'b1;
        end else if (scr_kind[a] != R_NONE) begin
          push_pkt(2'b10, 8'h5A);
        end
      end else if (scr_kind[a] == R_ACK) begin
        r.ok = 1'b1; r.chk_rd = 1'b0; r.rd = '0;
        exp_res.push_back(r);
        fin = 1'b1;
      end
    end
    if (!fin) begin
      r.ok = 1'b0; r.chk_rd = 1'b0; r.rd = '0;
      exp_res.push_back(r);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model queues.
  task automatic monitor();
    res_t r;
    if (bus.tx_load) begin
      n_loads++;
      chk("load_while_busy", in_flight, 1'b0);
      chk("load_expected", exp_pkt.size() > 0, 1'b1);
      if (exp_pkt.size() > 0) begin
        cur_pkt = exp_pkt.pop_front();
        chk("pkt_kind", bus.tx_kind, cur_pkt.kind);
        chk("pkt_pid", bus.tx_pid, cur_pkt.pid);
        chk("pkt_data", bus.tx_data, cur_wdata);
        chk("pkt_endp", bus.tx_endp, cur_endp);
        chk("pkt_addr", bus.tx_addr, 7'b1010000);
      end
      in_flight = 1'b1;
      enc_cnt   = ENC_LAT;
    end else if (in_flight) begin
      chk("pkt_hold", {bus.tx_kind, bus.tx_pid}, {cur_pkt.kind, cur_pkt.pid});
    end
    if (bus.rx_en) begin
      if (!rx_prev) begin
        win = 0;
        att++;
      end
      win++;
    end else if (rx_prev) begin
      chk("win_expected", exp_win.size() > 0, 1'b1);
      if (exp_win.size() > 0) chk("resp_window", win, exp_win.pop_front());
    end
    rx_prev = bus.rx_en;
    if (bus.txn_done) begin
      n_dones++;
      chk("done_expected", exp_res.size() > 0, 1'b1);
      if (exp_res.size() > 0) begin
        r = exp_res.pop_front();
        last_ok = r.ok;
        chk("txn_ok", bus.txn_ok, r.ok);
        if (r.chk_rd) chk("txn_rdata", bus.txn_rdata, r.rd);
        chk("pkts_left", exp_pkt.size(), 0);
        chk("wins_left", exp_win.size(), 0);
      end
    end
  endtask

  // Encoder and device behaviour for the coming clock edge.
  task automatic respond();
    bus.tx_done  = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_err   = 1'b0;
    bus.rx_pid   = '0;
    bus.rx_data  = '0;
    if (in_flight) begin
      enc_cnt--;
      if (enc_cnt == 0) begin
        bus.tx_done = 1'b1;
        in_flight   = 1'b0;
      end
    end
    if (bus.rx_en && att >= 0 && att < 16) begin
      if (scr_kind[att] != R_NONE && win == scr_delay[att]) begin
        bus.rx_valid = 1'b1;
        case (scr_kind[att])
          R_ACK:   bus.rx_pid = 8'h4B;
          R_NAK:   bus.rx_pid = 8'h5A;
          R_DATA:  begin bus.rx_pid = 8'hC3; bus.rx_data = scr_data; end
          default: begin bus.rx_pid = 8'hC3; bus.rx_err = 1'b1; bus.rx_data = 64'hBAD0_BAD0_BAD0_BAD0; end
        endcase
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    respond();
  endtask

  task automatic reset_bench_state();
    exp_pkt.delete();
    exp_win.delete();
    exp_res.delete();
    in_flight = 1'b0;
    rx_prev   = 1'b0;
    att       = -1;
  endtask

  task automatic launch();
    att = -1;
    bus.txn_start = 1'b1;
    bus.txn_type  = cur_type;
    bus.txn_endp  = cur_endp;
    bus.txn_wdata = cur_wdata;
    step();
    bus.txn_start = 1'b0;
    bus.txn_type  = 2'b00;
    bus.txn_endp  = ~cur_endp;
    bus.txn_wdata = ~cur_wdata;
    for (int c = 0; c < 6000 && exp_res.size() > 0; c++) step();
    chk("finished_in_budget", exp_res.size(), 0);
    reset_bench_state();
    repeat (2) step();
    chk("ok_held", bus.txn_ok, last_ok);
  endtask

  initial begin
    int  l0;
    int  d0;
    bit  seen;
    rst_b = 1'b0;
    bus.txn_start = 1'b0; bus.txn_type = '0; bus.txn_endp = '0; bus.txn_wdata = '0;
    bus.tx_done = 1'b0; bus.rx_valid = 1'b0; bus.rx_pid = '0; bus.rx_data = '0; bus.rx_err = 1'b0;
    n_loads = 0; n_dones = 0; last_ok = 1'b0; win = 0;
    reset_bench_state();
    clear_script();
    repeat (2) @(negedge clk);
    chk("rst_txn_done", bus.txn_done, 1'b0);
    chk("rst_txn_ok", bus.txn_ok, 1'b0);
    chk("rst_tx_load", bus.tx_load, 1'b0);
    chk("rst_rx_en", bus.rx_en, 1'b0);
    chk("rst_tx_kind", bus.tx_kind, 2'b00);
    chk("rst_tx_pid", bus.tx_pid, 8'h00);
    chk("rst_tx_data", bus.tx_data, 64'h0);
    chk("rst_txn_rdata", bus.txn_rdata, 64'h0);
    rst_b = 1'b1;

    // OUT acknowledged on first try.
    clear_script();
    scr_kind[0] = R_ACK; scr_delay[0] = 4;
    prepare(2'b10, 4'b0010, 64'hDEAD_BEEF_0123_4567);
    chk("model_out_npkt", exp_pkt.size(), 2);
    chk("model_out_tok", exp_pkt[0].pid, 8'h87);
    chk("model_out_data", exp_pkt[1].pid, 8'hC3);
    chk("model_out_ok", exp_res[0].ok, 1'b1);
    launch();

    // IN with clean data.
    clear_script();
    scr_kind[0] = R_DATA; scr_delay[0] = 6; scr_data = 64'h0F0F_0F0F_0F0F_0F0F;
    prepare(2'b01, 4'b0001, 64'h0);
    chk("model_in_hs", exp_pkt[1].pid, 8'h4B);
    chk("model_in_rd", exp_res[0].rd, 64'h0F0F_0F0F_0F0F_0F0F);
    launch();

    // OUT: NAK, NAK, ACK.
    clear_script();
    scr_kind[0] = R_NAK; scr_delay[0] = 3;
    scr_kind[1] = R_NAK; scr_delay[1] = 5;
    scr_kind[2] = R_ACK; scr_delay[2] = 2;
    prepare(2'b10, 4'b0011, 64'h1122_3344_5566_7788);
`ifdef USB_TXN_RETRY_EN
    chk("model_nak_npkt", exp_pkt.size(), 6);
    chk("model_nak_ok", exp_res[0].ok, 1'b1);
`else
    chk("model_nak_npkt", exp_pkt.size(), 2);
    chk("model_nak_ok", exp_res[0].ok, 1'b0);
`endif
    launch();

    // IN: corrupt first response, clean second.
    clear_script();
    scr_kind[0] = R_ERR;  scr_delay[0] = 2;
    scr_kind[1] = R_DATA; scr_delay[1] = 3; scr_data = 64'hA5A5_5A5A_0000_FFFF;
    prepare(2'b01, 4'b0101, 64'h0);
    chk("model_err_nak", exp_pkt[1].pid, 8'h5A);
`ifdef USB_TXN_RETRY_EN
    chk("model_err_npkt", exp_pkt.size(), 4);
`else
    chk("model_err_npkt", exp_pkt.size(), 2);
`endif
    launch();

    // No response at all.
    clear_script();
    prepare(2'b10, 4'b0110, 64'h5555_AAAA_5555_AAAA);
    chk("model_to_attempts", exp_win.size(), RETRIES + 1);
    chk("model_to_win", exp_win[0], 255);
    chk("model_to_ok", exp_res[0].ok, 1'b0);
    launch();

    // Response on the very cycle the wait expires.
    clear_script();
    scr_kind[0] = R_ACK; scr_delay[0] = 255;
    prepare(2'b10, 4'b1000, 64'h0BAD_F00D_1234_5678);
    chk("model_edge_win", exp_win[0], 255);
    chk("model_edge_ok", exp_res[0].ok, 1'b1);
    launch();

    // Invalid type requests are dropped.
    l0 = n_loads;
    bus.txn_start = 1'b1; bus.txn_type = 2'b11;
    step();
    bus.txn_type = 2'b00;
    step();
    bus.txn_start = 1'b0;
    repeat (10) step();
    chk("invalid_no_load", n_loads - l0, 0);
    chk("invalid_no_rx", bus.rx_en, 1'b0);

    // Reset while the OUT data packet is in flight.
    clear_script();
    prepare(2'b10, 4'b0111, 64'hCAFE_0000_FACE_0001);
    att = -1;
    bus.txn_start = 1'b1; bus.txn_type = 2'b10; bus.txn_endp = 4'b0111; bus.txn_wdata = cur_wdata;
    step();
    bus.txn_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (in_flight && cur_pkt.kind == 2'b01) seen = 1'b1;
    end
    chk("reached_data", seen, 1'b1);
    step();
    #2 rst_b = 1'b0;
    #1;
    chk("mid_rst_tx_load", bus.tx_load, 1'b0);
    chk("mid_rst_tx_pid", bus.tx_pid, 8'h00);
    chk("mid_rst_tx_kind", bus.tx_kind, 2'b00);
    chk("mid_rst_tx_data", bus.tx_data, 64'h0);
    chk("mid_rst_rdata", bus.txn_rdata, 64'h0);
    chk("mid_rst_ok", bus.txn_ok, 1'b0);
    chk("mid_rst_rx_en", bus.rx_en, 1'b0);
    reset_bench_state();
    bus.tx_done = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    l0 = n_loads;
    d0 = n_dones;
    repeat (20) step();
    chk("rst_no_done", n_dones - d0, 0);
    chk("rst_no_load", n_loads - l0, 0);

    // Normal operation resumes after the reset.
    clear_script();
    scr_kind[0] = R_DATA; scr_delay[0] = 1; scr_data = 64'h0123_4567_89AB_CDEF;
    prepare(2'b01, 4'b1111, 64'h0);
    launch();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
